// File: rtl/tape_fsk_tx.sv
// Cassette FSK transmitter: LSB-first byte serialiser emitting one full tone
// cycle per bit (long half-period for 0, short half-period for 1).
`timescale 1ns/1ps
module tape_fsk_tx #(
    parameter int unsigned HALF0 = 11932,
    parameter int unsigned HALF1 = 5966
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        play,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        cin,
    output logic        busy,
    output logic [15:0] byte_count
);

    localparam int unsigned HMAX = (HALF0 > HALF1) ? HALF0 : HALF1;
    localparam int unsigned CW   = $clog2(HMAX + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HIGH  = 2'd1;
    localparam logic [1:0] S_LOW   = 2'd2;
    localparam logic [1:0] S_PAUSE = 2'd3;

    localparam logic [CW-1:0] H0_CNT  = CW'(HALF0);
    localparam logic [CW-1:0] H1_CNT  = CW'(HALF1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic [15:0]   byte_count_q, byte_count_d;
    logic          cin_q, cin_d;
    logic          busy_q, busy_d;
    logic          in_ready_q, in_ready_d;
    logic          load;
    logic          accept;

    function automatic logic [CW-1:0] half_of(input logic bit_val);
        return bit_val ? H1_CNT : H0_CNT;
    endfunction

    // Next-state logic: tone sequencing, holding-register handshake, byte counter
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        byte_count_d = byte_count_q;
        load         = 1'b0;
        accept       = in_valid & ~hold_full_q;

        case (state_q)
            S_IDLE: begin
                if (hold_full_q && play) begin
                    load = 1'b1;
                end
            end
            S_HIGH: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = S_LOW;
                    cnt_d   = half_of(shift_q[0]);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_LOW: begin
                if (cnt_q == CNT_ONE) begin
                    if (idx_q != 3'd7) begin
                        // end of a non-final bit: advance, honour play only here
                        shift_d = {1'b0, shift_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                        if (play) begin
                            state_d = S_HIGH;
                            cnt_d   = half_of(shift_q[1]);
                        end else begin
                            state_d = S_PAUSE;
                        end
                    end else begin
                        byte_count_d = byte_count_q + 16'd1;
                        if (hold_full_q && play) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_PAUSE: begin
                if (play) begin
                    state_d = S_HIGH;
                    cnt_d   = half_of(shift_q[0]);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // load and accept are exclusive: load needs hold_full_q, accept needs it clear
        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            idx_d       = 3'd0;
            state_d     = S_HIGH;
            cnt_d       = half_of(hold_q[0]);
        end
        if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        cin_d      = (state_d == S_HIGH);
        busy_d     = (state_d != S_IDLE);
        in_ready_d = ~hold_full_d;
    end

    // State and output registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            idx_q        <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            byte_count_q <= '0;
            cin_q        <= 1'b0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            byte_count_q <= byte_count_d;
            cin_q        <= cin_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign cin        = cin_q;
    assign busy       = busy_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_tape_fsk_tx.sv
// Bench for tape_fsk_tx: decodes cin tone lengths back into bytes and checks
// timing, pause, backpressure, reset and counter wrap behaviour.
`timescale 1ns/1ps
module tb_tape_fsk_tx;

    localparam int H0 = 4;
    localparam int H1 = 2;

    typedef struct {
        logic [7:0] data;
        int         cycles;
    } vec_t;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        cin;
    logic        busy;
    logic [15:0] byte_count;

    tape_fsk_tx #(.HALF0(H0), .HALF1(H1)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .play       (play),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cin        (cin),
        .busy       (busy),
        .byte_count (byte_count)
    );

    always #5 clk_sys = ~clk_sys;

    int         total = 0;
    int         bad = 0;
    logic [7:0] got_q[$];
    int         mon_run = 0;
    int         mon_nb = 0;
    logic [7:0] mon_acc = 8'h00;
    int         busy_run = 0;
    int         last_run = 0;
    logic       prev_ready = 1'b1;
    int         rise_q[$];
    bit         rand_play = 1'b0;

    // Reference decoder: a high run of H1 cycles is a 1, H0 cycles is a 0, LSB first
    always @(negedge clk_sys) begin
        logic bitv;
        if (reset) begin
            mon_run  = 0;
            mon_nb   = 0;
            mon_acc  = 8'h00;
            busy_run = 0;
        end else begin
            if (cin) begin
                mon_run++;
            end else if (mon_run > 0) begin
                total++;
                bitv = (mon_run == H1);
                if (mon_run != H1 && mon_run != H0) begin
                    bad++;
                    $display("FAIL tone_len got=%0d want=%0d_or_%0d", mon_run, H1, H0);
                end
                mon_acc = {bitv, mon_acc[7:1]};
                mon_nb++;
                if (mon_nb == 8) begin
                    got_q.push_back(mon_acc);
                    mon_nb = 0;
                end
                mon_run = 0;
            end
            if (busy) begin
                busy_run++;
                if (in_ready && !prev_ready) rise_q.push_back(busy_run);
            end else begin
                if (busy_run > 0) last_run = busy_run;
                busy_run = 0;
            end
        end
        prev_ready = in_ready;
    end

    always @(negedge clk_sys) begin
        if (rand_play && ($urandom_range(0, 7) == 0)) play = ~play;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        if (got_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s got=none want=%0h", name, exp);
        end else begin
            chk(name, 32'(got_q.pop_front()), 32'(exp));
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk_sys);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 2000) begin
            @(negedge clk_sys);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout got=stalled want=accept data=%0h", b);
            in_valid = 1'b0;
        end else begin
            @(posedge clk_sys);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk_sys);
        while (!(busy == 1'b0 && in_ready == 1'b1) && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        if (!(busy == 1'b0 && in_ready == 1'b1)) begin
            total++;
            bad++;
            $display("FAIL idle_timeout got=busy%0b_ready%0b want=idle", busy, in_ready);
        end
        #1;
    endtask

    initial begin
        vec_t       tbl[6];
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic [15:0] cnt0;
        int         base;
        int         n;
        int         cin_hi;
        int         busy_hi;

        tbl[0] = '{8'h01, 60};
        tbl[1] = '{8'h00, 64};
        tbl[2] = '{8'hFF, 32};
        tbl[3] = '{8'hAA, 48};
        tbl[4] = '{8'h3C, 48};
        tbl[5] = '{8'h80, 60};

        // reset values
        repeat (3) @(negedge clk_sys);
        chk("rst_cin", 32'(cin), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_count", 32'(byte_count), 32'd0);
        reset = 1'b0;
        play  = 1'b1;

        // single bytes from idle
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].data);
            wait_idle(500);
            chk("vec_cycles", 32'(last_run), 32'(tbl[i].cycles));
            pop_chk("vec_byte", tbl[i].data);
            chk("vec_count", 32'(byte_count), 32'(i + 1));
        end

        // back-to-back plus backpressure
        base = rise_q.size();
        send(8'hFF);
        send(8'h00);
        chk("b2b_ready_low", 32'(in_ready), 32'd0);
        in_data  = 8'h77;
        in_valid = 1'b1;
        repeat (5) @(negedge clk_sys);
        chk("bp_ready_low", 32'(in_ready), 32'd0);
        in_data = 8'h99;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        chk("bp_ready_rise", 32'(in_ready), 32'd1);
        @(posedge clk_sys);
        #1;
        in_valid = 1'b0;
        wait_idle(1000);
        chk("b2b_run", 32'(last_run), 32'd144);
        pop_chk("b2b_byte0", 8'hFF);
        pop_chk("b2b_byte1", 8'h00);
        pop_chk("bp_byte2", 8'h99);
        chk("b2b_count", 32'(byte_count), 32'd9);
        chk("b2b_rises", 32'(rise_q.size() - base), 32'd3);
        if (rise_q.size() - base == 3) begin
            chk("rise_first", 32'(rise_q[base]), 32'd1);
            chk("rise_at_load", 32'(rise_q[base + 1]), 32'd33);
            chk("rise_at_load2", 32'(rise_q[base + 2]), 32'd97);
        end

        // pause during HIGH half of bit 2
        send(8'hAA);
        n = 0;
        do begin
            @(negedge clk_sys);
            #1;
            n++;
        end while (busy_run != 14 && n < 200);
        chk("pause_in_high", 32'(cin), 32'd1);
        play = 1'b0;
        repeat (12) @(negedge clk_sys);
        #1;
        chk("pause_cin", 32'(cin), 32'd0);
        chk("pause_busy", 32'(busy), 32'd1);
        chk("pause_bits", 32'(mon_nb), 32'd3);
        play = 1'b1;
        @(negedge clk_sys);
        chk("resume_hi0", 32'(cin), 32'd1);
        @(negedge clk_sys);
        chk("resume_hi1", 32'(cin), 32'd1);
        @(negedge clk_sys);
        chk("resume_half", 32'(cin), 32'd0);
        wait_idle(500);
        pop_chk("pause_byte", 8'hAA);
        chk("pause_count", 32'(byte_count), 32'd10);

        // reset mid-byte with a byte held
        send(8'hC3);
        send(8'h5A);
        n = 0;
        do begin
            @(negedge clk_sys);
            #1;
            n++;
        end while (!(mon_nb == 4 && cin) && n < 300);
        chk("rst_mid_reached", 32'(cin), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_cin", 32'(cin), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_count", 32'(byte_count), 32'd0);
        repeat (2) @(negedge clk_sys);
        reset   = 1'b0;
        cin_hi  = 0;
        busy_hi = 0;
        repeat (100) begin
            @(negedge clk_sys);
            if (cin) cin_hi++;
            if (busy) busy_hi++;
        end
        chk("post_rst_cin", 32'(cin_hi), 32'd0);
        chk("post_rst_busy", 32'(busy_hi), 32'd0);
        chk("post_rst_bytes", 32'(got_q.size()), 32'd0);

        // counter wrap via preload
        @(negedge clk_sys);
        force dut.byte_count_q = 16'hFFFE;
        @(posedge clk_sys);
        @(negedge clk_sys);
        release dut.byte_count_q;
        @(negedge clk_sys);
        chk("wrap_preload", 32'(byte_count), 32'hFFFE);
        send(8'hFF);
        wait_idle(500);
        chk("wrap_ffff", 32'(byte_count), 32'hFFFF);
        pop_chk("wrap_byte0", 8'hFF);
        send(8'h01);
        wait_idle(500);
        chk("wrap_zero", 32'(byte_count), 32'h0000);
        pop_chk("wrap_byte1", 8'h01);

        // randomized bytes with random play toggling
        cnt0 = byte_count;
        rand_play = 1'b1;
        for (int i = 0; i < 30; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            repeat ($urandom_range(0, 3)) @(negedge clk_sys);
            send(b);
        end
        rand_play = 1'b0;
        play = 1'b1;
        wait_idle(5000);
        for (int i = 0; i < 30; i++) begin
            pop_chk("rand_byte", exp_q[i]);
        end
        chk("rand_count", 32'(byte_count), 32'(16'(cnt0 + 16'd30)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
